// File: rtl/uart_intr_arbiter.sv
// Round-robin interrupt arbiter: latches UART event pulses per source and
// serves them one at a time on a single intr/ack pair, with a grant watchdog.
module uart_intr_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   set,
  input  logic           ack,
  input  logic           mask_we,
  input  logic [N-1:0]   mask_in,
  input  logic           err_clr,
  output logic           intr,
  output logic [IDW-1:0] id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   mask,
  output logic           busy,
  output logic           timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           intr_nx;
  logic [IDW-1:0] id_nx;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] last_id_nx;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  timer_nx;
  logic [N-1:0]   pending_nx;
  logic [N-1:0]   clr_vec;
  logic           err_nx;
  logic           fire;
  logic [N-1:0]   eligible;
  logic [IDW-1:0] winner;
  logic           win_valid;

  assign eligible = pending & mask;
  assign busy     = (state != IDLE);

  // Rotating search: the source just served gets lowest priority next time.
  always_comb begin
    logic [IDW-1:0] cand;
    cand      = '0;
    winner    = '0;
    win_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_id) + k) % N);
      if (!win_valid && eligible[cand]) begin
        winner    = cand;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    intr_nx    = intr;
    id_nx      = id;
    timer_nx   = timer;
    last_id_nx = last_id;
    clr_vec    = '0;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          state_nx = REQ;
          intr_nx  = 1'b1;
          id_nx    = winner;
          timer_nx = '0;
        end
      end
      REQ: begin
        if (ack) begin
          clr_vec[id] = 1'b1;
          last_id_nx  = id;
          intr_nx     = 1'b0;
          state_nx    = GAP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          // Unanswered request: drop it but leave the source pending for a retry.
          fire       = 1'b1;
          last_id_nx = id;
          intr_nx    = 1'b0;
          state_nx   = GAP;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      GAP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    pending_nx = (pending & ~clr_vec) | set;
    err_nx     = fire | (timeout_err & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      intr        <= 1'b0;
      id          <= '0;
      last_id     <= IDW'(N - 1);
      timer       <= '0;
      pending     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      intr        <= intr_nx;
      id          <= id_nx;
      last_id     <= last_id_nx;
      timer       <= timer_nx;
      pending     <= pending_nx;
      timeout_err <= err_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_in;
    end
  end

endmodule

// File: tb/tb_uart_intr_arbiter.sv
// Randomised bench for uart_intr_arbiter: a transaction-level model predicts
// grants into a queue that an independent monitor drains on each intr rise.
module tb_uart_intr_arbiter;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;
  localparam int TW      = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   set;
  logic           ack;
  logic           mask_we;
  logic [N-1:0]   mask_in;
  logic           err_clr;
  logic           intr;
  logic [IDW-1:0] id;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic mon_prev;

  // Reference model: which sources are pending, and which one is being served.
  bit [N-1:0] m_pend;
  bit [N-1:0] m_mask;
  int         m_last;
  bit         m_active;
  bit         m_gap;
  bit         m_err;
  int         m_gid;
  int         m_age;

  uart_intr_arbiter #(
    .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst), .set(set), .ack(ack), .mask_we(mask_we),
    .mask_in(mask_in), .err_clr(err_clr), .intr(intr), .id(id),
    .pending(pending), .mask(mask), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic score(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_pend   = '0;
    m_mask   = '0;
    m_last   = N - 1;
    m_active = 1'b0;
    m_gap    = 1'b0;
    m_err    = 1'b0;
    m_gid    = 0;
    m_age    = 0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge given the inputs held over it.
  task automatic modelStep(input logic [N-1:0] s, input logic a, input logic mwe,
                           input logic [N-1:0] mi, input logic ec);
    bit timed_out;
    int pick;
    timed_out = 1'b0;
    pick      = -1;
    if (m_active) begin
      if (a) begin
        m_pend[m_gid] = 1'b0;
        m_last        = m_gid;
        m_active      = 1'b0;
        m_gap         = 1'b1;
      end else if (m_age == TIMEOUT) begin
        timed_out = 1'b1;
        m_last    = m_gid;
        m_active  = 1'b0;
        m_gap     = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_last + off) % N;
        if (pick < 0 && m_pend[c] && m_mask[c]) pick = c;
      end
      if (pick >= 0) begin
        m_active = 1'b1;
        m_gid    = pick;
        m_age    = 1;
        exp_q.push_back(pick);
      end
    end
    m_pend = m_pend | s;
    m_err  = timed_out || (m_err && !ec);
    if (mwe) m_mask = mi;
  endtask

  task automatic checkOutput();
    score("intr", intr, m_active);
    score("busy", busy, m_active || m_gap);
    score("pending", pending, m_pend);
    score("mask", mask, m_mask);
    score("timeout_err", timeout_err, m_err);
    if (m_active) score("id_hold", id, m_gid);
  endtask

  task automatic applyStimulus(input logic [N-1:0] s, input logic a, input logic mwe,
                               input logic [N-1:0] mi, input logic ec);
    @(negedge clk);
    checkOutput();
    set     = s;
    ack     = a;
    mask_we = mwe;
    mask_in = mi;
    err_clr = ec;
    modelStep(s, a, mwe, mi, ec);
  endtask

  task automatic runService(input logic [N-1:0] first_set, input int cycles, input int ack_after);
    for (int i = 0; i < cycles; i++)
      applyStimulus((i == 0) ? first_set : '0, m_active && (m_age == ack_after), 1'b0, '0, 1'b0);
  endtask

  // Reset is applied mid-cycle to observe that it acts without a clock edge.
  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    set     = '0;
    ack     = 1'b0;
    mask_we = 1'b0;
    mask_in = '0;
    err_clr = 1'b0;
    #1;
    score("rst_intr", intr, 0);
    score("rst_pending", pending, 0);
    score("rst_busy", busy, 0);
    score("rst_mask", mask, 0);
    score("rst_timeout_err", timeout_err, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    mon_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && intr && !mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL grant_unexpected: got intr=1 id=%0d, expected no grant at %0t", id, $time);
        end else begin
          int e;
          e = exp_q.pop_front();
          score("grant_id", id, e);
        end
      end
      mon_prev = intr;
    end
  end

  initial begin
    logic [N-1:0] s;
    logic         a;
    rst     = 1'b1;
    set     = '0;
    ack     = 1'b0;
    mask_we = 1'b0;
    mask_in = '0;
    err_clr = 1'b0;
    modelReset();
    doReset();

    $display("[TB] directed: single source, ordering, masking");
    applyStimulus('0, 1'b0, 1'b1, 4'b1111, 1'b0);
    runService(4'b0100, 8, 3);
    runService(4'b1011, 18, 3);
    runService(4'b0010, 8, 2);
    runService(4'b1011, 18, 2);
    applyStimulus('0, 1'b0, 1'b1, 4'b1101, 1'b0);
    runService(4'b0010, 5, 0);
    applyStimulus('0, 1'b0, 1'b1, 4'b1111, 1'b0);
    runService('0, 8, 2);

    $display("[TB] directed: watchdog and set-during-ack");
    runService(4'b0001, 14, 0);
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b1);
    runService('0, 6, 1);
    runService(4'b0001, 3, 0);
    applyStimulus(4'b0001, m_active, 1'b0, '0, 1'b0);
    runService('0, 4, 0);
    doReset();

    $display("[TB] random traffic");
    applyStimulus('0, 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = '0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) s[b] = 1'b1;
      a = m_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 799) == 0)
        doReset();
      else
        applyStimulus(s, a, $urandom_range(0, 11) == 0, N'($urandom_range(0, 15)),
                      $urandom_range(0, 15) == 0);
    end

    applyStimulus('0, 1'b0, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 40; i++)
      applyStimulus('0, m_active, 1'b0, '0, 1'b0);
    @(negedge clk);
    score("grant_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
